johnson_decoder: RTL

- Receive end of the Johnson ring counter link: samples an N-bit Johnson-coded word and decodes it to a binary state index.
- Checks every code for legality and every step for correct succession.
- Locks onto a clean sequence and counts errors.
- Sits downstream of the Johnson ring counter, or any Johnson-coded source, as its decoder and checker.

---
 rtl/johnson_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/johnson_decoder.sv
// Johnson-code receive decoder: maps an N-bit Johnson word to its state index,
// flags illegal codes and broken succession, tracks lock and counts errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no trusted reference; waiting for a legal code
// LOCKING  | counting consecutive correct successor steps toward LOCK_CNT
// LOCKED   | sequence tracked; any illegal code or seq error drops lock
module johnson_decoder #(
   parameter int N        = 4,
   parameter int CNT_W    = $clog2(2*N),
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     code_in,
   input  logic             code_valid,
   input  logic             clear_err,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             illegal,
   output logic             seq_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKING  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   // 2N modulo 2^CNT_W; only ever used as 2N - popcount with popcount >= 1,
   // so the wrapped arithmetic still lands on the correct index.
   localparam logic [CNT_W-1:0] TWO_N  = CNT_W'(2*N);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(2*N-1);
   localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);

   state_t             state_q, state_d;
   logic [3:0]         run_q, run_d;
   logic [CNT_W-1:0]   prev_q, prev_d;
   logic               prev_ok_q, prev_ok_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               count_valid_q;
   logic               illegal_q;
   logic               seq_err_q;
   logic               locked_q;
   logic [ERR_W-1:0]   err_q, err_d;

   logic [CNT_W-1:0]   pop_cnt;
   logic [CNT_W-1:0]   trans_cnt;
   logic               legal;
   logic [CNT_W-1:0]   k;
   logic [CNT_W-1:0]   succ;
   logic               samp_ok;
   logic               samp_ill;
   logic               samp_seq;
   logic               err_event;

   always_comb begin
      pop_cnt   = '0;
      trans_cnt = '0;
      for (int i = 0; i < N; i++) begin
         pop_cnt = pop_cnt + CNT_W'(code_in[i]);
      end
      for (int i = 0; i < N-1; i++) begin
         trans_cnt = trans_cnt + CNT_W'(code_in[i] ^ code_in[i+1]);
      end
      legal = (trans_cnt <= CNT_W'(1));
      k     = code_in[N-1] ? (TWO_N - pop_cnt) : pop_cnt;
      succ  = (prev_q == LAST) ? '0 : (prev_q + CNT_W'(1));

      samp_ok   = code_valid & legal;
      samp_ill  = code_valid & ~legal;
      samp_seq  = samp_ok & prev_ok_q & (k != succ);
      err_event = samp_ill | samp_seq;
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      count_d   = count_q;
      prev_d    = prev_q;
      prev_ok_d = prev_ok_q;
      err_d     = err_q;

      if (samp_ok) begin
         count_d   = k;
         prev_d    = k;
         prev_ok_d = 1'b1;
      end else if (samp_ill) begin
         prev_ok_d = 1'b0;
      end

      case (state_q)
         UNLOCKED: begin
            if (samp_ok) begin
               state_d = LOCKING;
               run_d   = '0;
            end
         end
         LOCKING: begin
            if (samp_ill) begin
               state_d = UNLOCKED;
               run_d   = '0;
            end else if (samp_seq) begin
               run_d = '0;
            end else if (samp_ok) begin
               if (run_q + 4'd1 == LOCK_C) begin
                  state_d = LOCKED;
                  run_d   = '0;
               end else begin
                  run_d = run_q + 4'd1;
               end
            end
         end
         LOCKED: begin
            if (samp_ill || samp_seq) begin
               state_d = UNLOCKED;
               run_d   = '0;
            end
         end
         default: begin
            state_d = UNLOCKED;
            run_d   = '0;
         end
      endcase

      // A clear coinciding with a new error keeps that error counted.
      if (clear_err) begin
         err_d = err_event ? ERR_W'(1) : '0;
      end else if (err_event && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= UNLOCKED;
         run_q         <= '0;
         prev_q        <= '0;
         prev_ok_q     <= 1'b0;
         count_q       <= '0;
         count_valid_q <= 1'b0;
         illegal_q     <= 1'b0;
         seq_err_q     <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         run_q         <= run_d;
         prev_q        <= prev_d;
         prev_ok_q     <= prev_ok_d;
         count_q       <= count_d;
         count_valid_q <= samp_ok;
         illegal_q     <= samp_ill;
         seq_err_q     <= samp_seq;
         locked_q      <= (state_d == LOCKED);
         err_q         <= err_d;
      end
   end

   assign count_out   = count_q;
   assign count_valid = count_valid_q;
   assign illegal     = illegal_q;
   assign seq_err     = seq_err_q;
   assign locked      = locked_q;
   assign err_cnt     = err_q;

endmodule
